hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the IF/ID, ID/EX and EX/MEM registers. Drives per-stage
//  enable/flush and PC enable. Handles three cases:
//   - load-use stall (bubble into ID/EX)
//   - taken-branch flush (multi-cycle)
//   - whole-pipe freeze while data memory is busy, with a timeout flag
//  Sits beside the pipeline registers, between decode/EX/MEM status and the register enables.
// PARAMETERS
//  FLUSH_CYCLES  2     cycles IF/ID is flushed after a taken branch (>=1)
//  MEM_TIMEOUT   255   freeze cycles before mem_timeout_o is raised (>=1)
//  CNT_W         8     width of the memory-wait counter (2**CNT_W > MEM_TIMEOUT)
// PORTS
//  clk              in   1   clock, rising edge
//  rst_n            in   1   asynchronous reset, active low
//  id_rs1_i         in   5   rs1 index of instruction in ID
//  id_rs2_i         in   5   rs2 index of instruction in ID
//  id_uses_rs1_i    in   1   ID instruction reads rs1
//  id_uses_rs2_i    in   1   ID instruction reads rs2
//  ex_rd_i          in   5   destination index of instruction in EX
//  ex_mem_read_i    in   1   EX instruction is a load
//  ex_br_taken_i    in   1   branch/jump in EX resolved taken
//  mem_req_i        in   1   MEM stage has an active data-memory access
//  mem_ready_i      in   1   data memory completes access this cycle
//  pc_en_o          out  1   PC update enable
//  ifid_en_o        out  1   IF/ID load enable
//  ifid_flush_o     out  1   IF/ID clear to NOP
//  idex_en_o        out  1   ID/EX load enable
//  idex_flush_o     out  1   ID/EX clear to bubble (ctrl zero)
//  exmem_en_o       out  1   EX/MEM load enable
//  mem_timeout_o    out  1   sticky: freeze exceeded MEM_TIMEOUT
//  state_o          out  2   current state (debug)
//  stall_cnt_o      out  32  load-use stall count (optional feature)
//  flush_cnt_o      out  32  branch flush count (optional feature)
// BEHAVIOUR
//  Reset (rst_n low):
//   - state=RUN, run_q=0, counters=0
//   - all *_en_o=0, all *_flush_o=0, mem_timeout_o=0
//  Start-up: run_q is set on the first clk after reset release; outputs are gated by run_q,
//   so the pipe first advances in the 2nd cycle after release.
//  States: RUN=0, BR_FLUSH=1, MEM_WAIT=2. Outputs are combinational from state+inputs; no added latency.
//  Priority, highest first: freeze > branch > load-use.
//  Freeze:
//   - Condition: mem_req_i && !mem_ready_i, in any state.
//   - All enables=0 and flushes=0 in that same cycle.
//   - On entry from RUN/BR_FLUSH, save ret_state and the flush count; go MEM_WAIT; wait_cnt=1.
//   - In MEM_WAIT: wait_cnt increments (saturating).
//   - When wait_cnt==MEM_TIMEOUT: mem_timeout_o=1, held until reset.
//   - mem_ready_i=1 (or mem_req_i dropped): leave MEM_WAIT next edge, restore ret_state and its
//     count; outputs follow normal rules that cycle.
//   - ex_br_taken_i and load-use are ignored while frozen; EX/ID are held, so they are
//     re-evaluated after release.
//  Branch (RUN, not frozen, ex_br_taken_i=1):
//   - Outputs: ifid_flush_o=1, idex_flush_o=1; pc_en_o=1 (target loads); other enables=1.
//   - FLUSH_CYCLES>1: go BR_FLUSH with fcnt=FLUSH_CYCLES-1.
//   - In BR_FLUSH: ifid_flush_o=1, others normal; fcnt decrements each unfrozen cycle; RUN when fcnt hits 0.
//   - A new taken branch while in BR_FLUSH reloads fcnt.
//  Load-use (RUN, not frozen, no branch):
//   - Condition: ex_mem_read_i && ex_rd_i!=0 && ((id_uses_rs1_i && id_rs1_i==ex_rd_i) ||
//     (id_uses_rs2_i && id_rs2_i==ex_rd_i)).
//   - Outputs: pc_en_o=0, ifid_en_o=0, idex_flush_o=1, exmem_en_o=1. State stays RUN.
//   - Resolves naturally next cycle; x0 never stalls.
//  Reset mid-freeze or mid-flush: state/counters clear immediately; mem_timeout_o clears.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//   - stall_cnt_o increments on each load-use cycle.
//   - flush_cnt_o increments on each branch-taken accept.
//   - Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
//  HAZARD_PERF_CNT_EN undefined: both ports present and tied to 0; no counter flops.
// TESTING
//  1 Reset release, no hazards -> cycle 1 all en=0; from cycle 2 pc/ifid/idex/exmem_en=1, flushes=0.
//  2 ex_mem_read=1, ex_rd=5, id_rs2=5, uses_rs2=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1;
//    repeat with ex_rd=0 -> no stall.
//  3 FLUSH_CYCLES=2, ex_br_taken=1 with load-use also true -> ifid_flush=1, idex_flush=1, pc_en=1;
//    next cycle ifid_flush=1 only; then RUN.
//  4 mem_req=1, mem_ready=0 for 3 cycles during BR_FLUSH -> all en/flush=0, state_o=2;
//    on ready, BR_FLUSH resumes with remaining flush cycle.
//  5 MEM_TIMEOUT=4, freeze 6 cycles -> mem_timeout_o=1 from 4th freeze cycle, stays 1 after ready;
//    rst_n low clears it.
//  6 HAZARD_PERF_CNT_EN defined: 3 load-use + 2 branches -> stall_cnt_o=3, flush_cnt_o=2;
//    undefined -> both 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for the IF/ID, ID/EX and EX/MEM registers. Produces the
//   per-stage load enables and flushes plus the PC enable, covering:
//     - load-use stall (bubble into ID/EX, PC and IF/ID held)
//     - taken-branch flush (IF/ID flushed for FLUSH_CYCLES cycles)
//     - whole-pipe freeze while data memory is busy, with a sticky timeout
//   Priority, highest first: freeze > branch > load-use.
//
// Parameters
//   FLUSH_CYCLES  cycles IF/ID is flushed after a taken branch (>=1)
//   MEM_TIMEOUT   freeze cycles before mem_timeout_o is raised (>=1)
//   CNT_W         memory-wait counter width (2**CNT_W > MEM_TIMEOUT)
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_rs1_i/id_rs2_i          source register indices of the ID instruction
//   id_uses_rs1_i/_rs2_i       ID instruction actually reads rs1 / rs2
//   ex_rd_i, ex_mem_read_i     destination index / is-load of EX instruction
//   ex_br_taken_i              branch/jump in EX resolved taken
//   mem_req_i, mem_ready_i     MEM stage access active / completes this cycle
//   pc_en_o, *_en_o, *_flush_o pipeline register controls (combinational)
//   mem_timeout_o              sticky: a freeze reached MEM_TIMEOUT cycles
//   state_o                    current state: RUN=0, BR_FLUSH=1, MEM_WAIT=2
//   stall_cnt_o, flush_cnt_o   performance counters
//
// Configuration
//   HAZARD_PERF_CNT_EN  when defined, stall_cnt_o counts load-use cycles and
//                       flush_cnt_o counts accepted taken branches (32-bit,
//                       saturating). When undefined both ports read 0 and no
//                       counter flops exist.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 255,
   parameter int CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic        id_uses_rs1_i,
   input  logic        id_uses_rs2_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        ex_mem_read_i,
   input  logic        ex_br_taken_i,
   input  logic        mem_req_i,
   input  logic        mem_ready_i,
   output logic        pc_en_o,
   output logic        ifid_en_o,
   output logic        ifid_flush_o,
   output logic        idex_en_o,
   output logic        idex_flush_o,
   output logic        exmem_en_o,
   output logic        mem_timeout_o,
   output logic [1:0]  state_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   // Just wide enough to hold FLUSH_CYCLES-1.
   localparam int FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      BR_FLUSH = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   state_e             state_q, state_d;
   state_e             ret_state_q, ret_state_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic               timeout_q, timeout_d;
   logic               run_q;

   logic   frozen;
   logic   lu_hit;
   logic   br_acc;
   logic   lu_acc;
   logic   tmo_hit;
   state_e eff_state;

   assign frozen = mem_req_i && !mem_ready_i;

   // While in MEM_WAIT the pipe behaves as the state it was frozen from, so
   // the release cycle already follows the normal rules of that state.
   // fcnt_q is not touched while frozen, so it also serves as the saved count.
   assign eff_state = (state_q == MEM_WAIT) ? ret_state_q : state_q;

   // x0 is hardwired zero: a load targeting it never creates a dependency.
   assign lu_hit = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                   ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                    (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

   assign br_acc = run_q && !frozen && ex_br_taken_i;
   assign lu_acc = run_q && !frozen && !ex_br_taken_i &&
                   (eff_state == RUN) && lu_hit;

   // ---------------------------------------------------------------------------
   // Pipeline register controls
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      ifid_flush_o = 1'b0;
      idex_en_o    = 1'b0;
      idex_flush_o = 1'b0;
      exmem_en_o   = 1'b0;
      if (run_q && !frozen) begin
         pc_en_o    = 1'b1;
         ifid_en_o  = 1'b1;
         idex_en_o  = 1'b1;
         exmem_en_o = 1'b1;
         if (br_acc) begin
            // PC loads the target; both wrong-path instructions are killed.
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
         end else if (eff_state == BR_FLUSH) begin
            ifid_flush_o = 1'b1;
         end else if (lu_acc) begin
            // Hold PC and IF/ID, insert a bubble behind the load.
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_flush_o = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ret_state_d = ret_state_q;
      fcnt_d      = fcnt_q;
      wait_cnt_d  = wait_cnt_q;
      if (run_q) begin
         if (frozen) begin
            if (state_q != MEM_WAIT) begin
               ret_state_d = state_q;
               state_d     = MEM_WAIT;
               wait_cnt_d  = CNT_W'(1);
            end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end else begin
            state_d = eff_state;
            if (br_acc) begin
               // A branch inside BR_FLUSH restarts the flush window.
               fcnt_d = FCNT_W'(FLUSH_CYCLES - 1);
               if (FLUSH_CYCLES > 1) state_d = BR_FLUSH;
            end else if (eff_state == BR_FLUSH) begin
               if (fcnt_q <= FCNT_W'(1)) begin
                  fcnt_d  = '0;
                  state_d = RUN;
               end else begin
                  fcnt_d = fcnt_q - FCNT_W'(1);
               end
            end
         end
      end
   end

   // wait_cnt_d is the number of freeze cycles including the current one, so
   // the flag shows up in the very cycle the limit is reached.
   assign tmo_hit       = run_q && frozen && (wait_cnt_d == CNT_W'(MEM_TIMEOUT));
   assign timeout_d     = timeout_q | tmo_hit;
   assign mem_timeout_o = timeout_q | tmo_hit;
   assign state_o       = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         ret_state_q <= RUN;
         fcnt_q      <= '0;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_state_q <= ret_state_d;
         fcnt_q      <= fcnt_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         run_q       <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (lu_acc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (br_acc && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = 32'd0;
   assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4). Each step drives one
// cycle of inputs and queues the expected controls; the entry is popped and
// compared at the following falling edge.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_br_taken;
   logic        mem_req, mem_ready;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
   logic        mem_timeout;
   logic [1:0]  state;
   logic [31:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
      .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read), .ex_br_taken_i(ex_br_taken),
      .mem_req_i(mem_req), .mem_ready_i(mem_ready),
      .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_flush),
      .idex_en_o(idex_en), .idex_flush_o(idex_flush), .exmem_en_o(exmem_en),
      .mem_timeout_o(mem_timeout), .state_o(state),
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   // Control vectors: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
   localparam logic [5:0] E_OFF  = 6'b000000;
   localparam logic [5:0] E_NORM = 6'b110101;
   localparam logic [5:0] E_LU   = 6'b000111;
   localparam logic [5:0] E_BR   = 6'b111111;
   localparam logic [5:0] E_BRF  = 6'b111101;

   // Hazard patterns presented on the ID/EX inputs
   localparam logic [2:0] H_NONE  = 3'd0; // no load in EX
   localparam logic [2:0] H_RS2   = 3'd1; // load rd=5, ID reads rs2=5
   localparam logic [2:0] H_X0    = 3'd2; // load rd=0, ID reads x0
   localparam logic [2:0] H_RS1   = 3'd3; // load rd=7, ID reads rs1=7
   localparam logic [2:0] H_NOUSE = 3'd4; // load rd=9, rs2=9 but unused

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [31:0] EXP_STALLS  = 32'd3;
   localparam logic [31:0] EXP_FLUSHES = 32'd2;
`else
   localparam logic [31:0] EXP_STALLS  = 32'd0;
   localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

   typedef struct {
      logic       rst;
      logic       br;
      logic       mreq;
      logic       mrdy;
      logic [2:0] hz;
      logic [8:0] exp;   // {state, controls, mem_timeout}
   } step_t;

   logic [8:0] exp_q[$];

   function automatic step_t st(logic rst, logic br, logic mreq, logic mrdy,
                                logic [2:0] hz, logic [1:0] s, logic [5:0] c, logic t);
      step_t r;
      r.rst = rst; r.br = br; r.mreq = mreq; r.mrdy = mrdy; r.hz = hz;
      r.exp = {s, c, t};
      return r;
   endfunction

   task automatic drive(input step_t s);
      rst_n       = !s.rst;
      ex_br_taken = s.br;
      mem_req     = s.mreq;
      mem_ready   = s.mrdy;
      id_uses_rs1 = 1'b1;
      id_uses_rs2 = 1'b1;
      id_rs1      = 5'd1;
      id_rs2      = 5'd2;
      ex_rd       = 5'd5;
      ex_mem_read = 1'b0;
      case (s.hz)
         H_RS2:   begin ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5; end
         H_X0:    begin ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; end
         H_RS1:   begin ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd2; end
         H_NOUSE: begin ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b0; end
         default: ;
      endcase
   endtask

   function automatic logic [8:0] observed();
      return {state, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, mem_timeout};
   endfunction

   task automatic test_reset();
      step_t q[$];
      logic [8:0] want;
      q.push_back(st(1, 0, 0, 0, H_NONE, 2'd0, E_OFF,  0));
      q.push_back(st(1, 0, 0, 0, H_RS2,  2'd0, E_OFF,  0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_OFF,  0)); // release: still gated
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      foreach (q[i]) begin
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (observed() !== want) begin
            bad++;
            $display("FAIL reset[%0d] got=%b want=%b", i, observed(), want);
         end
         @(posedge clk); #1;
      end
      total++;
      if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         bad++;
         $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
      end
   endtask

   task automatic test_load_use();
      step_t q[$];
      logic [8:0] want;
      q.push_back(st(0, 0, 0, 0, H_RS2,   2'd0, E_LU,   0));
      q.push_back(st(0, 0, 0, 0, H_NONE,  2'd0, E_NORM, 0));
      q.push_back(st(0, 0, 0, 0, H_X0,    2'd0, E_NORM, 0));
      q.push_back(st(0, 0, 0, 0, H_RS1,   2'd0, E_LU,   0));
      q.push_back(st(0, 0, 0, 0, H_NOUSE, 2'd0, E_NORM, 0));
      q.push_back(st(0, 0, 0, 0, H_NONE,  2'd0, E_NORM, 0));
      foreach (q[i]) begin
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (observed() !== want) begin
            bad++;
            $display("FAIL load_use[%0d] got=%b want=%b", i, observed(), want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      step_t q[$];
      logic [8:0] want;
      q.push_back(st(0, 1, 0, 0, H_RS2,  2'd0, E_BR,   0)); // branch beats load-use
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd1, E_BRF,  0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      foreach (q[i]) begin
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (observed() !== want) begin
            bad++;
            $display("FAIL branch[%0d] got=%b want=%b", i, observed(), want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      step_t q[$];
      logic [8:0] want;
      q.push_back(st(0, 1, 0, 0, H_NONE, 2'd0, E_BR,   0));
      q.push_back(st(0, 1, 0, 0, H_NONE, 2'd1, E_BR,   0)); // reloads flush window
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd1, E_BRF,  0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      foreach (q[i]) begin
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (observed() !== want) begin
            bad++;
            $display("FAIL back_to_back[%0d] got=%b want=%b", i, observed(), want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_freeze();
      step_t q[$];
      logic [8:0] want;
      // Freeze in the middle of a branch flush
      q.push_back(st(0, 1, 0, 0, H_NONE, 2'd0, E_BR,   0));
      q.push_back(st(0, 0, 1, 0, H_NONE, 2'd1, E_OFF,  0));
      q.push_back(st(0, 0, 1, 0, H_NONE, 2'd2, E_OFF,  0));
      q.push_back(st(0, 0, 1, 0, H_NONE, 2'd2, E_OFF,  0));
      q.push_back(st(0, 0, 1, 1, H_NONE, 2'd2, E_BRF,  0)); // resumes remaining flush
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      // Load-use held through a freeze, released by dropping mem_req
      q.push_back(st(0, 0, 1, 0, H_RS2,  2'd0, E_OFF,  0));
      q.push_back(st(0, 0, 0, 0, H_RS2,  2'd2, E_LU,   0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      // Branch held through a freeze
      q.push_back(st(0, 1, 1, 0, H_NONE, 2'd0, E_OFF,  0));
      q.push_back(st(0, 1, 1, 0, H_NONE, 2'd2, E_OFF,  0));
      q.push_back(st(0, 1, 1, 1, H_NONE, 2'd2, E_BR,   0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd1, E_BRF,  0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      foreach (q[i]) begin
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (observed() !== want) begin
            bad++;
            $display("FAIL freeze[%0d] got=%b want=%b", i, observed(), want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      step_t q[$];
      logic [8:0] want;
      q.push_back(st(0, 0, 1, 0, H_NONE, 2'd0, E_OFF,  0));
      q.push_back(st(0, 0, 1, 0, H_NONE, 2'd2, E_OFF,  0));
      q.push_back(st(0, 0, 1, 0, H_NONE, 2'd2, E_OFF,  0));
      q.push_back(st(0, 0, 1, 0, H_NONE, 2'd2, E_OFF,  1)); // 4th freeze cycle
      q.push_back(st(0, 0, 1, 0, H_NONE, 2'd2, E_OFF,  1));
      q.push_back(st(0, 0, 1, 0, H_NONE, 2'd2, E_OFF,  1));
      q.push_back(st(0, 0, 1, 1, H_NONE, 2'd2, E_NORM, 1));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 1)); // sticky
      q.push_back(st(1, 0, 0, 0, H_NONE, 2'd0, E_OFF,  0)); // reset clears it
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_OFF,  0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      foreach (q[i]) begin
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (observed() !== want) begin
            bad++;
            $display("FAIL timeout[%0d] got=%b want=%b", i, observed(), want);
         end
         @(posedge clk); #1;
      end
   endtask

   // Runs right after the reset at the end of test_timeout, so counters start at 0.
   task automatic test_perf();
      step_t q[$];
      logic [8:0] want;
      q.push_back(st(0, 0, 0, 0, H_RS2,  2'd0, E_LU,   0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      q.push_back(st(0, 0, 0, 0, H_RS1,  2'd0, E_LU,   0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      q.push_back(st(0, 0, 1, 0, H_RS2,  2'd0, E_OFF,  0)); // frozen: not a stall
      q.push_back(st(0, 0, 0, 0, H_RS2,  2'd2, E_LU,   0));
      q.push_back(st(0, 1, 0, 0, H_NONE, 2'd0, E_BR,   0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd1, E_BRF,  0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      q.push_back(st(0, 1, 0, 0, H_NONE, 2'd0, E_BR,   0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd1, E_BRF,  0));
      q.push_back(st(0, 0, 0, 0, H_NONE, 2'd0, E_NORM, 0));
      foreach (q[i]) begin
         drive(q[i]);
         exp_q.push_back(q[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (observed() !== want) begin
            bad++;
            $display("FAIL perf[%0d] got=%b want=%b", i, observed(), want);
         end
         @(posedge clk); #1;
      end
      total++;
      if (stall_cnt !== EXP_STALLS) begin
         bad++;
         $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, EXP_STALLS);
      end
      total++;
      if (flush_cnt !== EXP_FLUSHES) begin
         bad++;
         $display("FAIL flush_cnt got=%0d want=%0d", flush_cnt, EXP_FLUSHES);
      end
   endtask

   initial begin
      drive(st(1, 0, 0, 0, H_NONE, 2'd0, E_OFF, 0));
      @(posedge clk); #1;
      test_reset();
      test_load_use();
      test_branch();
      test_back_to_back();
      test_freeze();
      test_timeout();
      test_perf();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
